// File: rtl/clock_ratio_meter_pkg.sv
// Shared types and default parameters for the clock ratio meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_t;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_LOCK_MATCHES = 4;
  localparam int DEF_TOLERANCE    = 1;

endpackage

// File: rtl/clock_ratio_meter_if.sv
// Signal bundle between a slow-clock source / result consumer and the meter.
import clk_meter_pkg::*;

interface clock_ratio_meter_if #(
  parameter int CNT_W = DEF_CNT_W
);
  logic             sclk_in;
  logic             meas_en;
  logic [CNT_W-1:0] half_period;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  // Stimulus / consumer side.
  modport master (
    output sclk_in, meas_en,
    input  half_period, meas_valid, locked, timeout
  );

  // Meter side.
  modport slave (
    input  sclk_in, meas_en,
    output half_period, meas_valid, locked, timeout
  );
endinterface

// File: rtl/clock_ratio_meter_sync_edge_detect.sv
// Two-flop synchronizer plus delay flop; flags a level change of either polarity.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);
  logic s1_q, s2_q, s3_q;

  // Synchronize the asynchronous input and keep one delayed copy for edge detection.
  // NOTE: non-blocking assignments make each flop take its predecessor's old value, so this is a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_o = s2_q ^ s3_q;
endmodule

// File: rtl/clock_ratio_meter.sv
// Measures the half-period of a slow clock in clk cycles and tracks lock.
import clk_meter_pkg::*;

module clock_ratio_meter #(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
  parameter int TOLERANCE    = DEF_TOLERANCE
) (
  input  logic               clk,
  input  logic               rst,
  clock_ratio_meter_if.slave meter_if
);
  localparam int MW = $clog2(LOCK_MATCHES + 1);

  meter_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [MW-1:0]    match_q, match_d;
  logic             have_prev_q, have_prev_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  logic             edge_evt;
  logic [CNT_W-1:0] meas;
  logic [CNT_W-1:0] diff;

  sync_edge_detect u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(meter_if.sclk_in),
    .edge_o (edge_evt)
  );

  // cnt never reaches all-ones when an edge is accepted, so cnt+1 cannot wrap.
  assign meas = cnt_q + CNT_W'(1);
  assign diff = (meas > prev_q) ? (meas - prev_q) : (prev_q - meas);

  // Next-state logic: counter, FSM, lock tracking and output pulses.
  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    half_d      = half_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = 1'b0;

    if (!meter_if.meas_en) begin
      state_d     = IDLE;
      cnt_d       = '0;
      match_d     = '0;
      locked_d    = 1'b0;
      have_prev_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM, MEASURE: begin
          if (&cnt_q) begin
            // No edge within counter range; a simultaneous edge becomes the new reference.
            timeout_d   = 1'b1;
            cnt_d       = '0;
            match_d     = '0;
            locked_d    = 1'b0;
            have_prev_d = 1'b0;
            state_d     = edge_evt ? MEASURE : ARM;
          end else if (edge_evt) begin
            cnt_d = '0;
            if (state_q == ARM) begin
              state_d     = MEASURE;
              have_prev_d = 1'b0;
            end else begin
              half_d  = meas;
              valid_d = 1'b1;
              if (!have_prev_q) begin
                match_d = '0;
              end else if (diff <= CNT_W'(TOLERANCE)) begin
                match_d = (match_q == MW'(LOCK_MATCHES)) ? match_q : match_q + MW'(1);
              end else begin
                match_d = '0;
              end
              have_prev_d = 1'b1;
              prev_d      = meas;
              locked_d    = (match_d == MW'(LOCK_MATCHES));
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      half_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      half_q      <= half_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
    end
  end

  assign meter_if.half_period = half_q;
  assign meter_if.meas_valid  = valid_q;
  assign meter_if.locked      = locked_q;
  assign meter_if.timeout     = timeout_q;
endmodule
